// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared register indices and EPC stack entry type for cp0_nested_intc
package cp0_pkg;

    localparam logic [2:0] CP0_STATUS  = 3'd0;
    localparam logic [2:0] CP0_MASK    = 3'd1;
    localparam logic [2:0] CP0_EPC     = 3'd2;
    localparam logic [2:0] CP0_PENDING = 3'd3;
    localparam logic [2:0] CP0_CAUSE   = 3'd4;
    localparam logic [2:0] CP0_VBASE   = 3'd5;

    // Stack entries are sized for the widest supported PC; narrower
    // instances zero-extend on push and use the low DW bits on read.
    localparam int CP0_PC_MAX = 64;

    typedef struct packed {
        logic [CP0_PC_MAX-1:0] pc;
        logic [2:0]            level;
    } cp0_stack_entry_t;

endpackage

// File: rtl/cp0_epc_stack.sv
// rtl/cp0_epc_stack.sv - DEPTH-entry LIFO of {pc, level} for nested interrupts
// Ports: in_CLK/in_RST_N clock and async active-low reset; push/din add an entry;
// pop removes the top; wr_top/wr_pc overwrite the top PC; top/full/empty/count
// report the current state (top reads 0 when empty).
module cp0_epc_stack
    import cp0_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  in_CLK,
    input  logic                  in_RST_N,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  wr_top,
    input  logic [CP0_PC_MAX-1:0] wr_pc,
    input  cp0_stack_entry_t      din,
    output cp0_stack_entry_t      top,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cp0_stack_entry_t mem [DEPTH];
    logic [CW-1:0]    top_idx;
    logic [IW-1:0]    top_ptr;
    logic [IW-1:0]    push_ptr;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign top_idx  = count - 1'b1;
    assign top_ptr  = top_idx[IW-1:0];
    assign push_ptr = count[IW-1:0];
    assign top      = empty ? '0 : mem[top_ptr];

    // Only the occupancy is reset; entries above count are never observed.
    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge in_CLK) begin
        if (push && !full) begin
            mem[push_ptr] <= din;
        end else if (wr_top && !empty) begin
            mem[top_ptr].pc <= wr_pc;
        end
    end

endmodule

// File: rtl/cp0_nested_intc.sv
// rtl/cp0_nested_intc.sv - CP0 register file with nested, preemptive N-source interrupt controller
// Ports: in_CLK/in_RST_N clock and async active-low reset; WE/rW/W register write;
// rA/A combinational register read; in_IRQ request lines; in_PC resume PC;
// in_ERET return pulse; out_TAKE/out_VECTOR take pulse and handler address;
// out_EPC top-of-stack return address; out_IE global enable; out_DEPTH occupancy.
module cp0_nested_intc
    import cp0_pkg::*;
#(
    parameter  int N_IRQ   = 4,
    parameter  int DEPTH   = 4,
    parameter  int DW      = 32,
    parameter  int VSTRIDE = 16,
    localparam int DCW     = $clog2(DEPTH + 1)
) (
    input  logic             in_CLK,
    input  logic             in_RST_N,
    input  logic             WE,
    input  logic [2:0]       rW,
    input  logic [DW-1:0]    W,
    input  logic [2:0]       rA,
    output logic [DW-1:0]    A,
    input  logic [N_IRQ-1:0] in_IRQ,
    input  logic [DW-1:0]    in_PC,
    input  logic             in_ERET,
    output logic             out_TAKE,
    output logic [DW-1:0]    out_VECTOR,
    output logic [DW-1:0]    out_EPC,
    output logic             out_IE,
    output logic [DCW-1:0]   out_DEPTH
);

    logic             ie;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] prev;
    logic [DW-1:0]    vbase;
    logic             take_q;
    logic [DW-1:0]    vector_q;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] take_clr;
    logic [2:0]       cand;
    logic             cand_valid;
    logic             take;
    logic [3:0]       cause;

    logic wr_status, wr_mask, wr_epc, wr_pending, wr_vbase;

    cp0_stack_entry_t      push_entry;
    cp0_stack_entry_t      top;
    logic [CP0_PC_MAX-1:0] pc_ext;
    logic [CP0_PC_MAX-1:0] wr_pc_ext;
    logic                  st_full;
    logic                  st_empty;
    logic [DCW-1:0]        st_count;

    assign wr_status  = WE && (rW == CP0_STATUS);
    assign wr_mask    = WE && (rW == CP0_MASK);
    assign wr_epc     = WE && (rW == CP0_EPC);
    assign wr_pending = WE && (rW == CP0_PENDING);
    assign wr_vbase   = WE && (rW == CP0_VBASE);

    assign rise = in_IRQ & ~prev;
    assign w1c  = wr_pending ? W[N_IRQ-1:0] : '0;

    // Fixed priority: scanning downwards leaves the lowest set index.
    always_comb begin
        cand       = '0;
        cand_valid = 1'b0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i] && mask[i]) begin
                cand       = 3'(i);
                cand_valid = 1'b1;
            end
        end
    end

    // Preemption is strict: an equal level never nests on itself. ERET
    // suppresses the take so push and pop never share an edge.
    assign take = ie && cand_valid && !st_full &&
                  (st_empty || (cand < top.level)) && !in_ERET;

    always_comb begin
        take_clr = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            take_clr[i] = take && (cand == 3'(i));
        end
    end

    always_comb begin
        pc_ext            = '0;
        pc_ext[DW-1:0]    = in_PC;
        wr_pc_ext         = '0;
        wr_pc_ext[DW-1:0] = W;
    end

    assign push_entry.pc    = pc_ext;
    assign push_entry.level = cand;

    cp0_epc_stack #(
        .DEPTH (DEPTH)
    ) u_stack (
        .in_CLK   (in_CLK),
        .in_RST_N (in_RST_N),
        .push     (take),
        .pop      (in_ERET && !st_empty),
        .wr_top   (wr_epc && !take && !in_ERET),
        .wr_pc    (wr_pc_ext),
        .din      (push_entry),
        .top      (top),
        .full     (st_full),
        .empty    (st_empty),
        .count    (st_count)
    );

    always_ff @(posedge in_CLK or negedge in_RST_N) begin
        if (!in_RST_N) begin
            ie       <= 1'b1;
            mask     <= '0;
            pending  <= '0;
            prev     <= '0;
            vbase    <= '0;
            take_q   <= 1'b0;
            vector_q <= '0;
        end else begin
            prev <= in_IRQ;
            // A new edge outranks both software clear and the take clear.
            pending <= (pending & ~w1c & ~take_clr) | rise;
            if (take) begin
                ie <= 1'b0;
            end else if (in_ERET) begin
                ie <= 1'b1;
            end else if (wr_status) begin
                ie <= W[0];
            end
            if (wr_mask) begin
                mask <= W[N_IRQ-1:0];
            end
            if (wr_vbase) begin
                vbase <= W;
            end
            take_q <= take;
            if (take) begin
                vector_q <= vbase + DW'(cand) * DW'(VSTRIDE);
            end
        end
    end

    assign cause = st_empty ? 4'd0 : ({1'b0, top.level} + 4'd1);

    always_comb begin
        A = '0;
        case (rA)
            CP0_STATUS:  A = DW'(ie);
            CP0_MASK:    A = DW'(mask);
            CP0_EPC:     A = top.pc[DW-1:0];
            CP0_PENDING: A = DW'(pending);
            CP0_CAUSE:   A = DW'(cause);
            CP0_VBASE:   A = vbase;
            default:     A = '0;
        endcase
    end

    assign out_TAKE   = take_q;
    assign out_VECTOR = vector_q;
    assign out_EPC    = top.pc[DW-1:0];
    assign out_IE     = ie;
    assign out_DEPTH  = st_count;

endmodule

// File: tb/tb_cp0_nested_intc.sv
// tb/tb_cp0_nested_intc.sv - scoreboard bench for cp0_nested_intc
module tb_cp0_nested_intc;
    import cp0_pkg::*;

    localparam int N_IRQ = 4;
    localparam int DEPTH = 2;
    localparam int DW    = 32;
    localparam int DCW   = $clog2(DEPTH + 1);

    logic             in_CLK = 1'b0;
    logic             in_RST_N;
    logic             WE;
    logic [2:0]       rW;
    logic [DW-1:0]    W;
    logic [2:0]       rA;
    logic [DW-1:0]    A;
    logic [N_IRQ-1:0] in_IRQ;
    logic [DW-1:0]    in_PC;
    logic             in_ERET;
    logic             out_TAKE;
    logic [DW-1:0]    out_VECTOR;
    logic [DW-1:0]    out_EPC;
    logic             out_IE;
    logic [DCW-1:0]   out_DEPTH;

    cp0_nested_intc #(
        .N_IRQ   (N_IRQ),
        .DEPTH   (DEPTH),
        .DW      (DW),
        .VSTRIDE (16)
    ) dut (
        .in_CLK     (in_CLK),
        .in_RST_N   (in_RST_N),
        .WE         (WE),
        .rW         (rW),
        .W          (W),
        .rA         (rA),
        .A          (A),
        .in_IRQ     (in_IRQ),
        .in_PC      (in_PC),
        .in_ERET    (in_ERET),
        .out_TAKE   (out_TAKE),
        .out_VECTOR (out_VECTOR),
        .out_EPC    (out_EPC),
        .out_IE     (out_IE),
        .out_DEPTH  (out_DEPTH)
    );

    always #5 in_CLK = ~in_CLK;

    typedef struct {
        int          cyc;
        logic [31:0] vec;
        logic [31:0] epc;
        int          depth;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge in_CLK) cyc++;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(negedge in_CLK) begin
        if (in_RST_N === 1'b1 && out_TAKE === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_take: got take at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("take_cycle", cyc, e.cyc);
                check("take_vector", out_VECTOR, e.vec);
                check("take_epc", out_EPC, e.epc);
                check("take_depth", 32'(out_DEPTH), e.depth);
                check("take_ie_cleared", 32'(out_IE), 0);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge in_CLK);
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        WE = 1'b1; rW = r; W = d;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] r, input logic [31:0] e, input string name);
        rA = r;
        #1;
        check(name, A, e);
    endtask

    task automatic expect_take(input int dc, input logic [31:0] vec, input logic [31:0] epc, input int depth);
        exp_t e;
        e.cyc = cyc + dc; e.vec = vec; e.epc = epc; e.depth = depth;
        q.push_back(e);
    endtask

    task automatic pulse_irq(input logic [N_IRQ-1:0] m);
        in_IRQ = m;
        tick();
        in_IRQ = '0;
    endtask

    task automatic eret();
        in_ERET = 1'b1;
        tick();
        in_ERET = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL take_timeout: got %0d outstanding takes expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_RST_N = 1'b0; WE = 1'b0; rW = '0; W = '0; rA = '0;
        in_IRQ = '0; in_PC = '0; in_ERET = 1'b0;
        tick(3);
        #1;
        check("rst_take", 32'(out_TAKE), 0);
        check("rst_vector", out_VECTOR, 0);
        check("rst_epc", out_EPC, 0);
        check("rst_depth", 32'(out_DEPTH), 0);
        check("rst_ie", 32'(out_IE), 1);
        rd(CP0_MASK, 0, "rst_mask");
        rd(CP0_CAUSE, 0, "rst_cause");
        tick();
        in_RST_N = 1'b1;
        tick();

        // Single IRQ on line 2
        wr(CP0_MASK, 32'h4);
        wr(CP0_VBASE, 32'h100);
        rd(CP0_VBASE, 32'h100, "vbase_rb");
        in_PC = 32'h40;
        expect_take(2, 32'h120, 32'h40, 1);
        pulse_irq(4'h4);
        rd(CP0_PENDING, 32'h4, "pending_visible");
        tick();
        rd(CP0_CAUSE, 3, "single_cause");
        check("single_ie", 32'(out_IE), 0);
        rd(CP0_PENDING, 0, "single_pending_clr");
        tick();
        check("no_back_to_back", 32'(out_TAKE), 0);
        eret();
        check("single_eret_depth", 32'(out_DEPTH), 0);
        check("single_eret_ie", 32'(out_IE), 1);
        check("single_eret_epc", out_EPC, 0);
        rd(CP0_CAUSE, 0, "single_eret_cause");

        // Priority: lines 1 and 3 together
        wr(CP0_MASK, 32'hF);
        in_PC = 32'h80;
        expect_take(2, 32'h110, 32'h80, 1);
        pulse_irq(4'hA);
        tick();
        rd(CP0_PENDING, 32'h8, "prio_pending3");
        rd(CP0_CAUSE, 2, "prio_cause1");
        in_PC = 32'h90;
        expect_take(2, 32'h130, 32'h90, 1);
        eret();
        tick();
        rd(CP0_CAUSE, 4, "prio_cause3");

        // Nesting: IRQ0 preempts handler 3, IRQ3 cannot
        wr(CP0_STATUS, 1);
        in_PC = 32'h200;
        expect_take(2, 32'h100, 32'h200, 2);
        pulse_irq(4'h1);
        tick();
        check("nest_depth", 32'(out_DEPTH), 2);
        rd(CP0_CAUSE, 1, "nest_cause");
        wr(CP0_STATUS, 1);
        pulse_irq(4'h8);
        tick(3);
        rd(CP0_PENDING, 32'h8, "nest_no_self_preempt");
        check("nest_depth_held", 32'(out_DEPTH), 2);
        wr(CP0_PENDING, 32'h8);
        rd(CP0_PENDING, 0, "nest_w1c");
        eret();
        check("nest_pop_epc", out_EPC, 32'h90);
        eret();
        check("nest_pop_empty", 32'(out_DEPTH), 0);

        // Overflow: two levels fill the stack, IRQ0 waits
        in_PC = 32'h300;
        expect_take(2, 32'h120, 32'h300, 1);
        pulse_irq(4'h4);
        tick();
        wr(CP0_STATUS, 1);
        in_PC = 32'h310;
        expect_take(2, 32'h110, 32'h310, 2);
        pulse_irq(4'h2);
        tick();
        wr(CP0_STATUS, 1);
        pulse_irq(4'h1);
        tick(3);
        rd(CP0_PENDING, 32'h1, "full_holds");
        check("full_depth", 32'(out_DEPTH), 2);
        in_PC = 32'h320;
        expect_take(2, 32'h100, 32'h320, 2);
        eret();
        tick();

        // ERET and eligible take on the same edge
        eret();
        check("coll_pre_depth", 32'(out_DEPTH), 1);
        in_PC = 32'h400;
        expect_take(3, 32'h110, 32'h400, 1);
        in_IRQ = 4'h2;
        tick();
        in_IRQ = '0;
        in_ERET = 1'b1;
        tick();
        in_ERET = 1'b0;
        check("eret_wins_depth", 32'(out_DEPTH), 0);
        tick();

        // Edge and W1C on the same bit
        WE = 1'b1; rW = CP0_PENDING; W = 32'h8;
        in_IRQ = 4'h8;
        tick();
        WE = 1'b0;
        rd(CP0_PENDING, 32'h8, "edge_beats_w1c");
        wr(CP0_PENDING, 32'h8);
        rd(CP0_PENDING, 0, "w1c_clears");
        in_IRQ = '0;
        wr(CP0_EPC, 32'h555);
        check("epc_write", out_EPC, 32'h555);
        rd(CP0_EPC, 32'h555, "epc_read");
        rd(3'd6, 0, "reg6_zero");

        // Reset mid-handler at full depth
        wr(CP0_STATUS, 1);
        in_PC = 32'h500;
        expect_take(2, 32'h100, 32'h500, 2);
        pulse_irq(4'h1);
        tick();
        drain();
        check("pre_reset_depth", 32'(out_DEPTH), 2);
        in_RST_N = 1'b0;
        #1;
        check("midrst_depth", 32'(out_DEPTH), 0);
        check("midrst_epc", out_EPC, 0);
        check("midrst_take", 32'(out_TAKE), 0);
        check("midrst_vector", out_VECTOR, 0);
        check("midrst_ie", 32'(out_IE), 1);
        rd(CP0_MASK, 0, "midrst_mask");
        rd(CP0_CAUSE, 0, "midrst_cause");
        tick(2);
        in_RST_N = 1'b1;
        tick(2);

        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
